bridge_rx: RTL and testbench
============================

# bridge_rx

Host-side bus initiator for the register bus that the IO and logic-analyzer cores respond on. It consumes bytes from the UART receiver and parses ASCII read/write commands. Each well-formed command becomes exactly one single-cycle bus transaction on addr_o/data_o/rw_o/valid_o, which feeds the head of the core daisy chain. Malformed or stalled commands are discarded and flagged.

## Interface
- TIMEOUT_CYCLES, default 1_000_000: maximum idle cycles between bytes of one command. Used only with BRIDGE_RX_TIMEOUT_EN.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_data_i  input  8  byte from the UART receiver.
- rx_valid_i  input  1  rx_data_i is valid this cycle; one byte is accepted per high cycle.
- addr_o  output  16  bus address.
- data_o  output  16  bus write data; 0 for reads.
- rw_o  output  1  1 = write, 0 = read.
- valid_o  output  1  one-cycle transaction strobe.
- err_o  output  1  one-cycle pulse on a discarded command.

## Operation
- Read command: 'R', then 4 hex digits of address, then a terminator.
- Write command: 'W', then 4 hex address digits, then 4 hex data digits, then a terminator.
- Terminator is '\r' (0x0D) or '\n' (0x0A). Hex digits are 0-9, A-F and a-f. Values are MSB nibble first.
- Command letters are uppercase only.
- FSM states and transitions:
  - IDLE: 'R' -> ADDR with rw=0. 'W' -> ADDR with rw=1. '\r' or '\n' -> ignored, so CRLF pairs are harmless. Any other byte -> err_o, stay in IDLE.
  - ADDR: hex digit -> shift into the address shift register. After the 4th digit, go to DATA if rw=1, else TERM.
  - DATA: hex digit -> shift into the data shift register. After the 4th digit, go to TERM.
  - TERM: terminator -> issue the transaction, go to IDLE.
  - In ADDR, DATA or TERM, any unexpected byte -> err_o, go to IDLE, no transaction issued.
- A 2-bit nibble counter is cleared on every state entry.
- Issuing a transaction loads addr_o, data_o (0 for reads) and rw_o, and pulses valid_o.
- addr_o, data_o and rw_o hold their values until the next transaction. Only valid_o and err_o pulse.
- There is no backpressure: the bus always accepts. valid_o and err_o are never asserted in the same cycle.

## Timing
- Reset values: addr_o=0, data_o=0, rw_o=0, valid_o=0, err_o=0, state=IDLE, shift registers=0, timeout counter=0.
- Reset is asynchronous: asserting rst_n mid-command aborts the command immediately, with no valid_o or err_o.
- A byte is accepted on the rising edge where rx_valid_i=1.
- Latency:
  - Terminator accepted at edge N -> valid_o high between edges N and N+1, outputs updated at edge N.
  - Bad byte accepted at edge N -> err_o high between edges N and N+1.
- Bytes may arrive on consecutive cycles. A new 'R'/'W' accepted in the cycle that valid_o is high is parsed normally.
- The minimum spacing between back-to-back transactions equals the command length in bytes (6 for reads, 10 for writes).

## Configuration
- BRIDGE_RX_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on every accepted byte and increments each cycle while state != IDLE.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE and err_o pulses for one cycle.
  - A byte arriving in that same cycle takes priority: it is accepted and the counter clears.
- BRIDGE_RX_TIMEOUT_EN undefined: no counter is built and TIMEOUT_CYCLES is unused. A partial command waits indefinitely.

## Structure
- Package bridge_pkg holds:
  - the state enum (IDLE, ADDR, DATA, TERM);
  - ASCII constants for 'R', 'W', CR and LF;
  - the bus width localparams (ADDR_W=16, DATA_W=16).
- One sub-module, hex_decode: combinational, 8-bit ASCII in -> 4-bit nibble plus is_hex flag.

## Test plan
- "R0001\r" -> one cycle after '\r': valid_o=1, addr_o=0x0001, rw_o=0, data_o=0x0000; err_o stays 0.
- "W0006BEEF\n" sent on back-to-back cycles -> single valid_o pulse with addr_o=0x0006, data_o=0xBEEF, rw_o=1. Outputs hold afterwards.
- "W000aabcd\r\n" -> addr_o=0x000A, data_o=0xABCD. The trailing '\n' produces no err_o and no second valid_o.
- "R00G1\r" -> err_o pulse one cycle after 'G', no valid_o. The following "1" and "\r" cause err_o and nothing respectively. A subsequent "R0002\r" yields addr_o=0x0002.
- With BRIDGE_RX_TIMEOUT_EN and TIMEOUT_CYCLES=20: send "R00", then idle for 20 cycles -> err_o pulse and return to IDLE. Then "R0003\r" -> valid_o with addr_o=0x0003.
- Drop rst_n between the 2nd and 3rd address digit of "R1234\r" -> all outputs 0 immediately, no valid_o. After release, "R0004\r" -> addr_o=0x0004.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and constants for the ASCII command receiver (bridge_rx).
package bridge_pkg;

    // Register bus widths.
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    // ASCII bytes recognised by the command parser.
    localparam logic [7:0] ASCII_R  = 8'h52;  // 'R'
    localparam logic [7:0] ASCII_W  = 8'h57;  // 'W'
    localparam logic [7:0] ASCII_CR = 8'h0D;  // '\r'
    localparam logic [7:0] ASCII_LF = 8'h0A;  // '\n'

    // Parser states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        TERM = 2'd3
    } state_e;

    // True for either command terminator.
    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/bridge_rx_hex_decode.sv
// Combinational ASCII hex digit decoder: 0-9, A-F, a-f -> nibble plus valid flag.
module hex_decode (
    input  logic [7:0] ascii_i,
    output logic [3:0] nibble_o,
    output logic       is_hex_o
);

    // Map the three ASCII digit ranges onto their nibble values.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
        nibble_o = 4'h0;
        is_hex_o = 1'b0;
        if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
            nibble_o = 4'(ascii_i - 8'h30);
            is_hex_o = 1'b1;
        end else if (ascii_i >= 8'h41 && ascii_i <= 8'h46) begin
            nibble_o = 4'(ascii_i - 8'h37);
            is_hex_o = 1'b1;
        end else if (ascii_i >= 8'h61 && ascii_i <= 8'h66) begin
            nibble_o = 4'(ascii_i - 8'h57);
            is_hex_o = 1'b1;
        end
    end

endmodule

// File: rtl/bridge_rx.sv
// ASCII command parser driving the register bus: "Raaaa<term>" reads,
// "Waaaadddd<term>" writes. Each well-formed command issues one bus strobe;
// malformed commands pulse err_o. Optional inter-byte watchdog is built when
// BRIDGE_RX_TIMEOUT_EN is defined.
module bridge_rx
    import bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              rw_o,
    output logic              valid_o,
    output logic              err_o
);

    state_e            state_q, state_d;
    logic [1:0]        nib_cnt_q, nib_cnt_d;
    logic [ADDR_W-1:0] addr_sr_q, addr_sr_d;
    logic [DATA_W-1:0] data_sr_q, data_sr_d;
    logic              rw_sr_q, rw_sr_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              rw_q, valid_q, err_q;
    logic              issue, bad_byte, timeout_hit;
    logic [3:0]        nibble;
    logic              is_hex;

    hex_decode u_hex_decode (
        .ascii_i  (rx_data_i),
        .nibble_o (nibble),
        .is_hex_o (is_hex)
    );

`ifdef BRIDGE_RX_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // A received byte wins over an expiring watchdog in the same cycle.
    assign timeout_hit = (state_q != IDLE) && !rx_valid_i && (tmo_q == TMO_W'(TIMEOUT_CYCLES));

    // Idle-cycle count since the last byte of a command in progress.
    always_comb begin
        tmo_d = tmo_q + 1'b1;
        if (rx_valid_i || state_q == IDLE || timeout_hit) tmo_d = '0;
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    assign timeout_hit = 1'b0;
    // Without the watchdog the timeout value has no effect; this keeps it referenced.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    // Next-state, shift-register and strobe decode for one received byte.
    always_comb begin
        state_d   = state_q;
        nib_cnt_d = nib_cnt_q;
        addr_sr_d = addr_sr_q;
        data_sr_d = data_sr_q;
        rw_sr_d   = rw_sr_q;
        issue     = 1'b0;
        bad_byte  = 1'b0;
        if (rx_valid_i) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_data_i == ASCII_R || rx_data_i == ASCII_W) begin
                        state_d   = ADDR;
                        rw_sr_d   = (rx_data_i == ASCII_W);
                        data_sr_d = '0;
                    end else if (!is_term(rx_data_i)) begin
                        bad_byte = 1'b1;  // stray CR/LF are silently dropped
                    end
                end
                ADDR: begin
                    if (is_hex) begin
                        addr_sr_d = {addr_sr_q[ADDR_W-5:0], nibble};
                        nib_cnt_d = nib_cnt_q + 1'b1;
                        if (nib_cnt_q == 2'd3) state_d = rw_sr_q ? DATA : TERM;
                    end else begin
                        bad_byte = 1'b1;
                        state_d  = IDLE;
                    end
                end
                DATA: begin
                    if (is_hex) begin
                        data_sr_d = {data_sr_q[DATA_W-5:0], nibble};
                        nib_cnt_d = nib_cnt_q + 1'b1;
                        if (nib_cnt_q == 2'd3) state_d = TERM;
                    end else begin
                        bad_byte = 1'b1;
                        state_d  = IDLE;
                    end
                end
                TERM: begin
                    if (is_term(rx_data_i)) issue = 1'b1;
                    else                    bad_byte = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout_hit) begin
            bad_byte = 1'b1;
            state_d  = IDLE;
        end
        // The nibble counter restarts on entry to any state.
        if (state_d != state_q) nib_cnt_d = '0;
    end

    // Parser state and shift registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q   <= IDLE;
            nib_cnt_q <= '0;
            addr_sr_q <= '0;
            data_sr_q <= '0;
            rw_sr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            nib_cnt_q <= nib_cnt_d;
            addr_sr_q <= addr_sr_d;
            data_sr_q <= data_sr_d;
            rw_sr_q   <= rw_sr_d;
        end
    end

    // Bus outputs: fields hold between transactions, strobes last one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            data_q  <= '0;
            rw_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= issue;
            err_q   <= bad_byte;
            if (issue) begin
                addr_q <= addr_sr_q;
                data_q <= rw_sr_q ? data_sr_q : '0;
                rw_q   <= rw_sr_q;
            end
        end
    end

    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign rw_o    = rw_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_bridge_rx.sv
// Self-checking bench for bridge_rx: table-driven command strings, hand-written
// reset/timeout sequences, and randomized traffic against a command-buffer model.
// Watchdog sequences are included when BRIDGE_RX_TIMEOUT_EN is defined.
module tb_bridge_rx;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] addr_o, data_o;
    logic        rw_o, valid_o, err_o;

    int total = 0;
    int bad   = 0;
    int n_valid, n_err;

    // Reference model: the bytes of the command collected so far.
    byte unsigned cmd_q[$];
    logic [15:0]  m_addr, m_data;
    logic         m_rw, m_valid, m_err;
    int           m_idle;

    bridge_rx #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .addr_o     (addr_o),
        .data_o     (data_o),
        .rw_o       (rw_o),
        .valid_o    (valid_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int hex_val(input byte unsigned b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        if (b >= "a" && b <= "f") return int'(b) - 87;
        return -1;
    endfunction

    function automatic bit is_term_b(input byte unsigned b);
        return b == 8'h0D || b == 8'h0A;
    endfunction

    task automatic model_reset();
        cmd_q.delete();
        m_addr = '0; m_data = '0; m_rw = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_idle = 0;
    endtask

    // Command-level model: a command is a letter followed by fixed-length hex fields and a terminator.
    task automatic model_step(input bit v, input byte unsigned b);
        int pos, len, acc;
        bit ok;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (v) begin
            m_idle = 0;
            if (cmd_q.size() == 0) begin
                if (b == "R" || b == "W") cmd_q.push_back(b);
                else if (!is_term_b(b)) m_err = 1'b1;
            end else begin
                pos = cmd_q.size();
                len = (cmd_q[0] == "W") ? 10 : 6;
                ok  = (pos == len - 1) ? is_term_b(b) : (hex_val(b) >= 0);
                if (!ok) begin
                    m_err = 1'b1;
                    cmd_q.delete();
                end else if (pos == len - 1) begin
                    m_valid = 1'b1;
                    m_rw    = (cmd_q[0] == "W");
                    acc = 0;
                    for (int i = 1; i <= 4; i++) acc = acc * 16 + hex_val(cmd_q[i]);
                    m_addr = 16'(acc);
                    acc = 0;
                    if (m_rw) for (int i = 5; i <= 8; i++) acc = acc * 16 + hex_val(cmd_q[i]);
                    m_data = 16'(acc);
                    cmd_q.delete();
                end else begin
                    cmd_q.push_back(b);
                end
            end
        end
`ifdef BRIDGE_RX_TIMEOUT_EN
        else if (cmd_q.size() != 0) begin
            if (m_idle == TMO) begin
                m_err = 1'b1;
                cmd_q.delete();
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
`endif
    endtask

    // One clock: drive on the falling edge, compare 1 ns after the rising edge.
    task automatic cycle(input bit v, input byte unsigned b);
        @(negedge clk);
        rx_valid = v;
        rx_data  = v ? b : 8'($urandom);
        @(posedge clk);
        model_step(v, b);
        #1;
        check("valid_o", valid_o, m_valid);
        check("err_o",   err_o,   m_err);
        check("addr_o",  addr_o,  m_addr);
        check("data_o",  data_o,  m_data);
        check("rw_o",    rw_o,    m_rw);
        if (valid_o) n_valid++;
        if (err_o)   n_err++;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h00);
    endtask

    typedef struct {
        string       cmd;
        logic [15:0] addr;
        logic [15:0] data;
        logic        rw;
        int          nv;
        int          ne;
    } vec_t;

    vec_t vecs[12];

    string       hexchars = "0123456789ABCDEFabcdef";
    string       noise    = "RW\015\n0aZg!r ";
    byte unsigned cmd_b[$];

    initial begin
        vecs[0]  = '{"R0001\015",                 16'h0001, 16'h0000, 1'b0, 1, 0};
        vecs[1]  = '{"W0006BEEF\n",               16'h0006, 16'hBEEF, 1'b1, 1, 0};
        vecs[2]  = '{"W000aabcd\015\n",           16'h000A, 16'hABCD, 1'b1, 1, 0};
        vecs[3]  = '{"R00G1\015",                 16'h000A, 16'hABCD, 1'b1, 0, 2};
        vecs[4]  = '{"R0002\015",                 16'h0002, 16'h0000, 1'b0, 1, 0};
        vecs[5]  = '{"R12345\015",                16'h0002, 16'h0000, 1'b0, 0, 1};
        vecs[6]  = '{"r0001\015",                 16'h0002, 16'h0000, 1'b0, 0, 5};
        vecs[7]  = '{"\015\n\015\n",              16'h0002, 16'h0000, 1'b0, 0, 0};
        vecs[8]  = '{"W12\015",                   16'h0002, 16'h0000, 1'b0, 0, 1};
        vecs[9]  = '{"R0001\015W00ff1234\015",    16'h00FF, 16'h1234, 1'b1, 2, 0};
        vecs[10] = '{"Wffff0000\015",             16'hFFFF, 16'h0000, 1'b1, 1, 0};
        vecs[11] = '{"RABCD\n",                   16'hABCD, 16'h0000, 1'b0, 1, 0};

        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst_n    = 1'b0;
        model_reset();
        #12;
        check("reset addr_o",  addr_o,  16'h0000);
        check("reset data_o",  data_o,  16'h0000);
        check("reset rw_o",    rw_o,    1'b0);
        check("reset valid_o", valid_o, 1'b0);
        check("reset err_o",   err_o,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven command strings.
        for (int i = 0; i < 12; i++) begin
            n_valid = 0;
            n_err   = 0;
            send_str(vecs[i].cmd);
            idle(3);
            check($sformatf("vec%0d valid count", i), n_valid, vecs[i].nv);
            check($sformatf("vec%0d err count", i),   n_err,   vecs[i].ne);
            check($sformatf("vec%0d addr", i),        addr_o,  vecs[i].addr);
            check($sformatf("vec%0d data", i),        data_o,  vecs[i].data);
            check($sformatf("vec%0d rw", i),          rw_o,    vecs[i].rw);
        end

        // Asynchronous reset in the middle of "R1234\r".
        n_valid = 0;
        n_err   = 0;
        send_str("R12");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midreset addr_o",  addr_o,  16'h0000);
        check("midreset data_o",  data_o,  16'h0000);
        check("midreset rw_o",    rw_o,    1'b0);
        check("midreset valid_o", valid_o, 1'b0);
        check("midreset err_o",   err_o,   1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_str("R0004\015");
        idle(2);
        check("post-reset addr", addr_o, 16'h0004);
        check("post-reset valid count", n_valid, 1);
        check("post-reset err count", n_err, 0);

`ifdef BRIDGE_RX_TIMEOUT_EN
        // Stalled command times out, then a fresh command still works.
        n_valid = 0;
        n_err   = 0;
        send_str("R00");
        idle(TMO + 5);
        check("timeout err count", n_err, 1);
        check("timeout valid count", n_valid, 0);
        send_str("R0003\015");
        idle(2);
        check("after timeout addr", addr_o, 16'h0003);
        check("after timeout valid count", n_valid, 1);

        // A byte arriving on the expiry cycle wins over the watchdog.
        n_valid = 0;
        n_err   = 0;
        send_str("R0");
        idle(TMO);
        send_str("007\015");
        idle(2);
        check("edge timeout err count", n_err, 0);
        check("edge timeout addr", addr_o, 16'h0007);
`endif

        // Randomized traffic: well-formed commands with gaps, mixed with noise.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) != 0) begin
                cmd_b.delete();
                cmd_b.push_back($urandom_range(0, 1) ? "W" : "R");
                for (int j = 0; j < ((cmd_b[0] == "W") ? 8 : 4); j++)
                    cmd_b.push_back(hexchars[$urandom_range(0, hexchars.len() - 1)]);
                cmd_b.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
                foreach (cmd_b[j]) begin
                    cycle(1'b1, cmd_b[j]);
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                end
            end else begin
                repeat ($urandom_range(1, 4)) begin
                    if ($urandom_range(0, 1) != 0)
                        cycle(1'b1, noise[$urandom_range(0, noise.len() - 1)]);
                    else if ($urandom_range(0, 9) == 0)
                        idle(TMO + 2);
                    else
                        cycle(1'b1, 8'($urandom));
                end
            end
        end
        idle(TMO + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
